// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 cracker: PRGA state encoding and the
// plaintext character-class helper used by the decrypt stage and reporting.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_WT_I,
        ST_LD_I,
        ST_RD_J,
        ST_WT_J,
        ST_LD_J,
        ST_WR_I,
        ST_WR_J,
        ST_RD_F,
        ST_WT_F,
        ST_LD_F,
        ST_WR_OUT,
        ST_FINISH
    } prga_state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO_A  = 8'h61;
    localparam logic [7:0] CHAR_LO_Z  = 8'h7A;

    // Plaintext is expected to be lower-case words separated by spaces.
    function automatic logic is_valid_char(input logic [7:0] ch);
        return (ch == CHAR_SPACE) || ((ch >= CHAR_LO_A) && (ch <= CHAR_LO_Z));
    endfunction

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext byte classifier: valid when space or 'a'..'z'.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] ch,
    output logic       valid
);

    // NOTE: a single continuous assign covers every input value, so no latch can be inferred.
    assign valid = is_valid_char(ch);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA / decrypt stage: walks the KSA-scrambled S array, XORs the keystream
// with the ciphertext ROM, writes plaintext, and optionally aborts on a non-text byte.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN  = 32,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       ready,
    output logic       done,
    output logic       fail,
    output logic [7:0] s_addr,
    output logic [7:0] s_data,
    output logic       s_wren,
    input  logic [7:0] s_q,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_q,
    output logic [7:0] out_addr,
    output logic [7:0] out_data,
    output logic       out_wren
);

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    prga_state_t state;
    logic [7:0]  i, j, k;
    logic [7:0]  si, sj, f;
    logic        byte_ok;
    logic        abort;

    // rom_q still holds msg[k] during WR_OUT, so f ^ rom_q is the byte just written.
    rc4_char_check u_char_check (
        .ch    (f ^ rom_q),
        .valid (byte_ok)
    );

    assign abort = CHECK_EN && !byte_ok;

    // Outputs are loaded on the edge entering each state, so every address and
    // write strobe is already stable for the whole cycle of the state it belongs to.
    // NOTE: the S and plaintext RAMs are external and deliberately not reset; only control state is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            i        <= 8'd0;
            j        <= 8'd0;
            k        <= 8'd0;
            si       <= 8'd0;
            sj       <= 8'd0;
            f        <= 8'd0;
            fail     <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            s_addr   <= 8'd0;
            s_data   <= 8'd0;
            s_wren   <= 1'b0;
            rom_addr <= 8'd0;
            out_addr <= 8'd0;
            out_data <= 8'd0;
            out_wren <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below reads pre-edge register values.
            s_wren   <= 1'b0;
            out_wren <= 1'b0;
            done     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        i        <= 8'd1;
                        j        <= 8'd0;
                        k        <= 8'd0;
                        fail     <= 1'b0;
                        ready    <= 1'b0;
                        s_addr   <= 8'd1;
                        rom_addr <= 8'd0;
                        state    <= ST_RD_I;
                    end
                end
                ST_RD_I: state <= ST_WT_I;
                ST_WT_I: state <= ST_LD_I;
                ST_LD_I: begin
                    si     <= s_q;
                    j      <= j + s_q;
                    s_addr <= j + s_q;
                    state  <= ST_RD_J;
                end
                ST_RD_J: state <= ST_WT_J;
                ST_WT_J: state <= ST_LD_J;
                ST_LD_J: begin
                    sj     <= s_q;
                    s_addr <= i;
                    s_data <= s_q;
                    s_wren <= 1'b1;
                    state  <= ST_WR_I;
                end
                ST_WR_I: begin
                    s_addr <= j;
                    s_data <= si;
                    s_wren <= 1'b1;
                    state  <= ST_WR_J;
                end
                ST_WR_J: begin
                    s_addr <= si + sj;
                    state  <= ST_RD_F;
                end
                ST_RD_F: state <= ST_WT_F;
                ST_WT_F: state <= ST_LD_F;
                ST_LD_F: begin
                    f        <= s_q;
                    out_addr <= k;
                    out_data <= s_q ^ rom_q;
                    out_wren <= 1'b1;
                    state    <= ST_WR_OUT;
                end
                ST_WR_OUT: begin
                    i <= i + 8'd1;
                    if ((k == LAST_K) || abort) begin
                        fail  <= abort;
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end else begin
                        k        <= k + 8'd1;
                        rom_addr <= k + 8'd1;
                        s_addr   <= i + 8'd1;
                        state    <= ST_RD_I;
                    end
                end
                ST_FINISH: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: table-driven short messages on a
// MSG_LEN=2 instance plus full 256-byte runs against a plain RC4 model.
module tb_rc4_prga_decrypt;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: MSG_LEN=2, CHECK_EN=1
    logic       a_start, a_ready, a_done, a_fail, a_s_wren, a_out_wren;
    logic [7:0] a_s_addr, a_s_data, a_s_q, a_rom_addr, a_rom_q, a_out_addr, a_out_data;
    // Instance C: MSG_LEN=256, CHECK_EN=0
    logic       c_start, c_ready, c_done, c_fail, c_s_wren, c_out_wren;
    logic [7:0] c_s_addr, c_s_data, c_s_q, c_rom_addr, c_rom_q, c_out_addr, c_out_data;

    rc4_prga_decrypt #(.MSG_LEN(2), .CHECK_EN(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .ready(a_ready), .done(a_done), .fail(a_fail),
        .s_addr(a_s_addr), .s_data(a_s_data), .s_wren(a_s_wren), .s_q(a_s_q),
        .rom_addr(a_rom_addr), .rom_q(a_rom_q),
        .out_addr(a_out_addr), .out_data(a_out_data), .out_wren(a_out_wren)
    );

    rc4_prga_decrypt #(.MSG_LEN(256), .CHECK_EN(1'b0)) u_dut_c (
        .clk(clk), .reset(reset), .start(c_start), .ready(c_ready), .done(c_done), .fail(c_fail),
        .s_addr(c_s_addr), .s_data(c_s_data), .s_wren(c_s_wren), .s_q(c_s_q),
        .rom_addr(c_rom_addr), .rom_q(c_rom_q),
        .out_addr(c_out_addr), .out_data(c_out_data), .out_wren(c_out_wren)
    );

    // Memory models: 2-cycle read latency (address register + output register)
    logic [7:0] a_s[256], a_rom[256], a_out[256];
    logic [7:0] c_s[256], c_rom[256], c_out[256];
    logic [7:0] init_s[256];
    logic       a_load, c_load;
    logic [7:0] a_s_a1, a_r_a1, c_s_a1, c_r_a1;
    int         a_wcnt = 0, c_wcnt = 0, a_viol = 0, c_viol = 0;

    always @(posedge clk) begin
        if (a_load) for (int x = 0; x < 256; x++) a_s[x] <= init_s[x];
        else if (a_s_wren) a_s[a_s_addr] <= a_s_data;
        a_s_a1  <= a_s_addr;
        a_s_q   <= a_s[a_s_a1];
        a_r_a1  <= a_rom_addr;
        a_rom_q <= a_rom[a_r_a1];
        if (a_out_wren) begin
            a_out[a_out_addr] <= a_out_data;
            a_wcnt <= a_wcnt + 1;
        end
        if (a_s_wren && a_out_wren) a_viol <= a_viol + 1;
    end

    always @(posedge clk) begin
        if (c_load) for (int x = 0; x < 256; x++) c_s[x] <= init_s[x];
        else if (c_s_wren) c_s[c_s_addr] <= c_s_data;
        c_s_a1  <= c_s_addr;
        c_s_q   <= c_s[c_s_a1];
        c_r_a1  <= c_rom_addr;
        c_rom_q <= c_rom[c_r_a1];
        if (c_out_wren) begin
            c_out[c_out_addr] <= c_out_data;
            c_wcnt <= c_wcnt + 1;
        end
        if (c_s_wren && c_out_wren) c_viol <= c_viol + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_s(input bit sel);
        if (sel) c_load = 1'b1; else a_load = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        c_load = 1'b0;
    endtask

    task automatic set_identity();
        for (int x = 0; x < 256; x++) init_s[x] = 8'(x);
    endtask

    // Pulses start, returns cycles from accept to done (-1 on timeout) and plaintext writes seen.
    task automatic run(input bit sel, input int budget, output int cyc, output int wr);
        int w0;
        w0  = sel ? c_wcnt : a_wcnt;
        cyc = -1;
        if (sel) c_start = 1'b1; else a_start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            c_start = 1'b0;
            if ((sel ? c_done : a_done) == 1'b1) begin
                cyc = c;
                break;
            end
        end
        wr = (sel ? c_wcnt : a_wcnt) - w0;
        @(negedge clk);
    endtask

    // Reference: textbook RC4 PRGA over a copy of init_s, applied to c_rom.
    logic [7:0] ms[256];
    logic [7:0] exp_pt[256];
    task automatic model_run();
        int mi, mj, t;
        mi = 0;
        mj = 0;
        for (int x = 0; x < 256; x++) ms[x] = init_s[x];
        for (int n = 0; n < 256; n++) begin
            mi = (mi + 1) % 256;
            mj = (mj + int'(ms[mi])) % 256;
            t = int'(ms[mi]);
            ms[mi] = ms[mj];
            ms[mj] = 8'(t);
            exp_pt[n] = c_rom[n] ^ ms[(int'(ms[mi]) + int'(ms[mj])) % 256];
        end
    endtask

    task automatic ksa(input int klen);
        logic [7:0] key[8];
        int kj, t;
        for (int x = 0; x < klen; x++) key[x] = 8'($urandom_range(255));
        set_identity();
        kj = 0;
        for (int x = 0; x < 256; x++) begin
            kj = (kj + int'(init_s[x]) + int'(key[x % klen])) % 256;
            t = int'(init_s[x]);
            init_s[x] = init_s[kj];
            init_s[kj] = 8'(t);
        end
    endtask

    typedef struct {
        logic [7:0] e0, e1;
        logic [7:0] x0, x1;
        logic       xf;
        int         cyc;
        int         wr;
    } vec_t;

    vec_t vt[7];
    int   cyc, wr, nbad, dones, rdy_bad;
    logic r26, r27, found;

    initial begin
        // identity S gives keystream 8'h02, 8'h05 for the first two bytes
        vt[0] = '{8'h63, 8'h64, 8'h61, 8'h61, 1'b0, 25, 2};
        vt[1] = '{8'h02, 8'h64, 8'h00, 8'h00, 1'b1, 13, 1};
        vt[2] = '{8'h22, 8'h7F, 8'h20, 8'h7A, 1'b0, 25, 2};
        vt[3] = '{8'h62, 8'h64, 8'h60, 8'h00, 1'b1, 13, 1};
        vt[4] = '{8'h79, 8'h64, 8'h7B, 8'h00, 1'b1, 13, 1};
        vt[5] = '{8'h63, 8'h24, 8'h61, 8'h21, 1'b1, 25, 2};
        vt[6] = '{8'h78, 8'h75, 8'h7A, 8'h70, 1'b0, 25, 2};

        reset   = 1'b1;
        a_start = 1'b0;
        c_start = 1'b0;
        a_load  = 1'b0;
        c_load  = 1'b0;
        set_identity();
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", a_ready, 1);
        check("rst_done", a_done, 0);
        check("rst_fail", a_fail, 0);
        check("rst_wrens", {a_s_wren, a_out_wren}, 0);
        check("rst_addrs", {a_s_addr, a_rom_addr, a_out_addr}, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            set_identity();
            load_s(1'b0);
            a_rom[0] = vt[v].e0;
            a_rom[1] = vt[v].e1;
            run(1'b0, 100, cyc, wr);
            check($sformatf("vec%0d_out0", v), a_out[0], vt[v].x0);
            if (vt[v].wr == 2) check($sformatf("vec%0d_out1", v), a_out[1], vt[v].x1);
            check($sformatf("vec%0d_fail", v), a_fail, vt[v].xf);
            check($sformatf("vec%0d_cycles", v), cyc, vt[v].cyc);
            check($sformatf("vec%0d_writes", v), wr, vt[v].wr);
            check($sformatf("vec%0d_ready", v), a_ready, 1);
            if (v == 0) check("swap_s123", {a_s[1], a_s[2], a_s[3]}, {8'd1, 8'd3, 8'd2});
        end

        // start held high for 40 cycles: one run, a second accept only once ready returns
        set_identity();
        load_s(1'b0);
        a_rom[0] = 8'h60;
        a_rom[1] = 8'h64;
        dones = 0;
        rdy_bad = 0;
        r26 = 1'b0;
        r27 = 1'b1;
        a_start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= 25 && a_ready) rdy_bad++;
            if (a_done) dones++;
            if (c == 26) r26 = a_ready;
            if (c == 27) r27 = a_ready;
        end
        a_start = 1'b0;
        check("hold_ready_low", rdy_bad, 0);
        check("hold_one_done", dones, 1);
        check("hold_ready_back", r26, 1);
        check("hold_restart", r27, 0);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (a_done) found = 1'b1;
        end
        check("hold_second_done", found, 1);
        @(negedge clk);
        check("hold_second_out", {a_out[0], a_out[1]}, {8'h63, 8'h63});

        // reset during the first swap write
        set_identity();
        load_s(1'b0);
        a_rom[0] = 8'h63;
        a_rom[1] = 8'h64;
        a_start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (a_s_wren) found = 1'b1;
        end
        check("mid_wr_i_seen", found, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_wrens", {a_s_wren, a_out_wren}, 0);
        check("mid_rst_ready", a_ready, 1);
        check("mid_rst_done_fail", {a_done, a_fail}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_identity();
        load_s(1'b0);
        run(1'b0, 100, cyc, wr);
        check("post_rst_out", {a_out[0], a_out[1]}, {8'h61, 8'h61});
        check("post_rst_cycles", cyc, 25);

        // full-length runs: identity S with an invalid first byte, then a random key
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) set_identity(); else ksa(5);
            for (int x = 0; x < 256; x++) c_rom[x] = 8'($urandom_range(255));
            if (pass == 0) c_rom[0] = 8'h02;
            load_s(1'b1);
            model_run();
            run(1'b1, 4000, cyc, wr);
            if (pass == 0) check("nocheck_out0", c_out[0], 8'h00);
            for (int x = 0; x < 256; x++)
                check($sformatf("p%0d_byte%0d", pass, x), c_out[x], exp_pt[x]);
            nbad = 0;
            for (int x = 0; x < 256; x++) if (c_s[x] !== ms[x]) nbad++;
            check($sformatf("p%0d_final_s", pass), nbad, 0);
            check($sformatf("p%0d_fail", pass), c_fail, 0);
            check($sformatf("p%0d_cycles", pass), cyc, 12 * 256 + 1);
            check($sformatf("p%0d_writes", pass), wr, 256);
        end

        check("one_wren_a", a_viol, 0);
        check("one_wren_c", c_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
